// File: rtl/load_scoreboard.sv
// ============================================================================
// Module   : load_scoreboard
// Purpose  : Load-use interlock. A 3-bit down-counter per architectural
//            register tracks pending load results. Decode stalls while any
//            source register of the decode bundle is still busy.
//            Optional macro LOAD_SCOREBOARD_STATS_EN adds a saturating
//            stall-cycle counter; otherwise stall_cycles is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_scoreboard #(
  parameter int LOAD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dc_valid,
  input  logic [4:0]  ixu1_dc_rs1,
  input  logic [4:0]  ixu1_dc_rs2,
  input  logic [4:0]  ixu2_dc_rs1,
  input  logic [4:0]  ixu2_dc_rs2,
  input  logic [4:0]  lsu_dc_rs1,
  input  logic [4:0]  lsu_dc_rs2,
  input  logic [4:0]  bru_dc_rs1,
  input  logic [4:0]  bru_dc_rs2,
  input  logic        issue_valid,
  input  logic        lsu_issue_is_load,
  input  logic [4:0]  lsu_issue_rd,
  input  logic        flush,
  output logic        stall_out,
  output logic [31:0] busy_mask,
  output logic [31:0] stall_cycles
);

  localparam logic [2:0] LAT_INIT = 3'(LOAD_LAT);

  logic       accept;
  logic       load_en;
  logic [4:0] src [8];
  logic       src_hit;

  // A stalled or flushed bundle never reaches execute, so its load is dropped.
  assign accept  = issue_valid & ~stall_out & ~flush;
  assign load_en = accept & lsu_issue_is_load & (lsu_issue_rd != 5'd0);

  generate
    for (genvar r = 1; r < 32; r++) begin : g_cnt
      logic [2:0] cnt_q;
      logic [2:0] cnt_d;

      // A fresh load to this register restarts the count, even if still busy.
      always_comb begin
        cnt_d = cnt_q;
        if (load_en && (lsu_issue_rd == 5'(r))) begin
          cnt_d = LAT_INIT;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= 3'd0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign busy_mask[r] = (cnt_q != 3'd0);
    end
  endgenerate

  assign busy_mask[0] = 1'b0;

  assign src[0] = ixu1_dc_rs1;
  assign src[1] = ixu1_dc_rs2;
  assign src[2] = ixu2_dc_rs1;
  assign src[3] = ixu2_dc_rs2;
  assign src[4] = lsu_dc_rs1;
  assign src[5] = lsu_dc_rs2;
  assign src[6] = bru_dc_rs1;
  assign src[7] = bru_dc_rs2;

  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      src_hit = src_hit | ((src[i] != 5'd0) & busy_mask[src[i]]);
    end
  end

  assign stall_out = dc_valid & ~flush & src_hit;

`ifdef LOAD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_out && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_load_scoreboard.sv
// ============================================================================
// Module   : tb_load_scoreboard
// Purpose  : Directed scoreboard bench for load_scoreboard (LOAD_LAT = 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_scoreboard;

  logic        clk;
  logic        rst;
  logic        dc_valid;
  logic [4:0]  src [8];
  logic        issue_valid;
  logic        lsu_issue_is_load;
  logic [4:0]  lsu_issue_rd;
  logic        flush;
  logic        stall_out;
  logic [31:0] busy_mask;
  logic [31:0] stall_cycles;

  typedef struct {
    string       tag;
    logic        stall;
    logic [31:0] mask;
    logic [31:0] sc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] sc_model = 32'd0;

  load_scoreboard #(.LOAD_LAT(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .dc_valid          (dc_valid),
    .ixu1_dc_rs1       (src[0]),
    .ixu1_dc_rs2       (src[1]),
    .ixu2_dc_rs1       (src[2]),
    .ixu2_dc_rs2       (src[3]),
    .lsu_dc_rs1        (src[4]),
    .lsu_dc_rs2        (src[5]),
    .bru_dc_rs1        (src[6]),
    .bru_dc_rs2        (src[7]),
    .issue_valid       (issue_valid),
    .lsu_issue_is_load (lsu_issue_is_load),
    .lsu_issue_rd      (lsu_issue_rd),
    .flush             (flush),
    .stall_out         (stall_out),
    .busy_mask         (busy_mask),
    .stall_cycles      (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string tag, input logic s, input logic [31:0] m);
    exp_t e;
    e.tag   = tag;
    e.stall = s;
    e.mask  = m;
    e.sc    = sc_model;
    exp_q.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    e = exp_q.pop_front();
    n_total++;
    assert (stall_out === e.stall) n_pass++;
    else $error("FAIL %s.stall_out: observed %b expected %b", e.tag, stall_out, e.stall);
    n_total++;
    assert (busy_mask === e.mask) n_pass++;
    else $error("FAIL %s.busy_mask: observed %h expected %h", e.tag, busy_mask, e.mask);
    n_total++;
    assert (stall_cycles === e.sc) n_pass++;
    else $error("FAIL %s.stall_cycles: observed %0d expected %0d", e.tag, stall_cycles, e.sc);
  endtask

  // One cycle: drive just after the edge, check at the falling edge.
  task automatic step(input string tag, input logic dcv, input int slot,
                      input logic [4:0] rs, input logic iv, input logic ld,
                      input logic [4:0] rd, input logic fl,
                      input logic exp_s, input logic [31:0] exp_m);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) src[i] = 5'd0;
    src[slot]         = rs;
    dc_valid          = dcv;
    issue_valid       = iv;
    lsu_issue_is_load = ld;
    lsu_issue_rd      = rd;
    flush             = fl;
    push_exp(tag, exp_s, exp_m);
    @(negedge clk);
    compare_front();
`ifdef LOAD_SCOREBOARD_STATS_EN
    if (exp_s) sc_model = sc_model + 32'd1;
`endif
  endtask

  initial begin
    rst               = 1'b1;
    dc_valid          = 1'b1;
    for (int i = 0; i < 8; i++) src[i] = 5'd0;
    src[0]            = 5'd5;
    issue_valid       = 1'b0;
    lsu_issue_is_load = 1'b0;
    lsu_issue_rd      = 5'd0;
    flush             = 1'b0;
    #2;
    push_exp("reset", 1'b0, 32'h0);
    compare_front();
    @(negedge clk);
    rst = 1'b0;

    // Load x5 then read it back-to-back; a load in the stalled bundle is dropped.
    step("ld5",      1'b0, 0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0000_0000);
    step("rd5_c1",   1'b1, 0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 32'h0000_0020);
    step("rd5_c2",   1'b1, 0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 32'h0000_0020);
    step("rd5_c3",   1'b1, 0, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0000);

    step("ldx0",     1'b0, 0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0000_0000);
    step("rdx0",     1'b1, 3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0000);

    step("ld7_a",    1'b0, 0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0000_0000);
    step("ld7_b",    1'b0, 0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0000_0080);
    step("ld7_c2",   1'b0, 0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0080);
    step("ld7_c3",   1'b0, 0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0080);
    step("ld7_done", 1'b0, 0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0000);

    // Flush suppresses both the stall and the load issued alongside it.
    step("ld9",      1'b0, 0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 32'h0000_0000);
    step("flush",    1'b1, 7, 5'd9, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 32'h0000_0200);
    step("post_fl",  1'b1, 7, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0200);
    step("ld9_done", 1'b1, 7, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0000);

    // Reader one cycle late stalls once; load x3 issues with an unstalled reader.
    step("ld12",     1'b0, 0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 32'h0000_0000);
    step("ld12_gap", 1'b0, 0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_1000);
    step("rd12_lt",  1'b1, 5, 5'd12, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_1000);
    step("rd12_ok",  1'b1, 5, 5'd12, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0000_0000);
    step("rst_pre",  1'b1, 2, 5'd3, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 32'h0000_0008);

    // Asynchronous reset mid-count clears state without waiting for an edge.
    #2;
    rst = 1'b1;
    #1;
    sc_model = 32'd0;
    push_exp("rst_mid", 1'b0, 32'h0);
    compare_front();
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1'b1, 2, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0000);

    step("ld31",     1'b0, 0, 5'd0,  1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 32'h0000_0000);
    step("rd31_c1",  1'b1, 6, 5'd31, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 32'h8000_0000);
    step("rd31_c2",  1'b1, 6, 5'd31, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 32'h8000_0000);
    step("rd31_c3",  1'b1, 6, 5'd31, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
